// File: rtl/fetch_predecode.sv
// Instruction fetch + pre-decode: owns the PC, fetches over imem req/ack, presents decoded IR fields.
// Optional build macro FETCH_ILLEGAL_DET_EN enables unsupported-opcode detection and flag masking.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | out of reset, no request yet; moves to S_REQ on next clock
// S_REQ   | imem_req high on fetch_addr, waiting for imem_ack
// S_VALID | IR holds a live instruction, waiting for id_ready
module fetch_predecode #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INSN = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      OP,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic            LOAD,
  output logic            STORE,
  output logic            BType,
  output logic            illegal
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fetch_addr;
  logic [31:0]     ir;
  logic            redir_pend;
  logic [XLEN-1:0] redir_tgt;
  logic            unused_redir_lsb;

  assign redir_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign imem_addr        = fetch_addr;

  // fetch_addr is separate from pc so the bus address holds while a redirect is pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      ir         <= NOP_INSN;
      id_pc      <= RESET_PC;
      redir_pend <= 1'b0;
      imem_req   <= 1'b0;
      id_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
          if (redirect_valid) begin
            pc         <= redir_tgt;
            fetch_addr <= redir_tgt;
          end else begin
            fetch_addr <= pc;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            pc <= redir_tgt;
            if (imem_ack) begin
              redir_pend <= 1'b0;
              fetch_addr <= redir_tgt;
            end else begin
              redir_pend <= 1'b1;
            end
          end else if (imem_ack) begin
            if (redir_pend) begin
              redir_pend <= 1'b0;
              fetch_addr <= pc;
            end else begin
              ir       <= imem_rdata;
              id_pc    <= fetch_addr;
              pc       <= pc + XLEN'(4);
              imem_req <= 1'b0;
              id_valid <= 1'b1;
              state    <= S_VALID;
            end
          end
        end
        S_VALID: begin
          if (redirect_valid) begin
            pc         <= redir_tgt;
            fetch_addr <= redir_tgt;
            ir         <= NOP_INSN;
            id_valid   <= 1'b0;
            imem_req   <= 1'b1;
            state      <= S_REQ;
          end else if (id_ready) begin
            fetch_addr <= pc;
            id_valid   <= 1'b0;
            imem_req   <= 1'b1;
            state      <= S_REQ;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
          id_valid <= 1'b0;
        end
      endcase
    end
  end

  assign OP     = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rd     = ir[11:7];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  always_comb begin
    imm = '0;
    case (OP)
      7'b0010011, 7'b0000011, 7'b1100111:
        imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
      7'b0100011:
        imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011:
        imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      7'b1101111:
        imm = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

`ifdef FETCH_ILLEGAL_DET_EN
  logic legal_op;

  always_comb begin
    legal_op = 1'b0;
    case (OP)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b1100111: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  assign illegal = id_valid & ~legal_op;
`else
  assign illegal = 1'b0;
`endif

  assign LOAD  = (OP == 7'b0000011) & ~illegal;
  assign STORE = (OP == 7'b0100011) & ~illegal;
  assign BType = (OP == 7'b1100011) & ~illegal;

endmodule

// File: tb/tb_fetch_predecode.sv
// Randomized bench for fetch_predecode: transaction-level PC model plus an arithmetic decode reference.
module tb_fetch_predecode;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [6:0]  OP;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        LOAD, STORE, BType, illegal;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc;

  fetch_predecode dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .OP(OP), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .LOAD(LOAD), .STORE(STORE), .BType(BType), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic legal_op(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
  endfunction

  // Immediate rebuilt arithmetically: sign part times weight plus field times bit position
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int s;
    s = $signed(w);
    case (w[6:0])
      7'h13, 7'h03, 7'h67: return 32'(s >>> 20);
      7'h23: return 32'((s >>> 25) * 32 + int'(w[11:7]));
      7'h63: return 32'((s >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
      7'h6F: return 32'((s >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_decode(input logic [31:0] w);
    logic ill;
`ifdef FETCH_ILLEGAL_DET_EN
    ill = !legal_op(w[6:0]);
`else
    ill = 1'b0;
`endif
    check_val("op", OP, w[6:0]);
    check_val("funct3", funct3, w[14:12]);
    check_val("funct7", funct7, w[31:25]);
    check_val("rd", rd, w[11:7]);
    check_val("rs1", rs1, w[19:15]);
    check_val("rs2", rs2, w[24:20]);
    check_val("imm", imm, ref_imm(w));
    check_val("illegal", illegal, ill);
    check_val("load", LOAD, (w[6:0] == 7'h03) && !ill);
    check_val("store", STORE, (w[6:0] == 7'h23) && !ill);
    check_val("btype", BType, (w[6:0] == 7'h63) && !ill);
  endtask

  // mode: 0 plain, 1 redirect in REQ before ack, 2 redirect with ack, 3 redirect in VALID
  task automatic fetch_one(input logic [31:0] w, input int delay, input int mode,
                           input logic [31:0] tgt, input int hold);
    int          waited;
    logic [31:0] a;
    waited = 0;
    while (!imem_req && waited < 8) begin
      step();
      waited++;
    end
    check_val("req_high", imem_req, 1'b1);
    if (!imem_req) return;
    a = m_pc;
    check_val("fetch_addr", imem_addr, a);
    if (mode == 1 && delay == 0) mode = 2;
    for (int c = 0; c <= delay; c++) begin
      imem_ack       = (c == delay);
      imem_rdata     = (c == delay) ? w : $urandom;
      redirect_valid = (mode == 1 && c == 0) || (mode == 2 && c == delay);
      redirect_pc    = tgt;
      step();
      imem_ack       = 1'b0;
      redirect_valid = 1'b0;
      imem_rdata     = $urandom;
      if (c < delay) begin
        check_val("addr_hold", imem_addr, a);
        check_val("req_hold", imem_req, 1'b1);
      end
    end
    if (mode == 1 || mode == 2) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      check_val("drop_valid", id_valid, 1'b0);
      check_val("drop_req", imem_req, 1'b1);
      check_val("redir_addr", imem_addr, m_pc);
      return;
    end
    check_val("valid", id_valid, 1'b1);
    check_val("req_low", imem_req, 1'b0);
    check_val("id_pc", id_pc, a);
    check_decode(w);
    m_pc = a + 32'd4;
    for (int h = 0; h < hold; h++) begin
      step();
      check_val("stall_valid", id_valid, 1'b1);
      check_val("stall_req", imem_req, 1'b0);
      check_val("stall_imm", imm, ref_imm(w));
      check_val("stall_op", OP, w[6:0]);
    end
    if (mode == 3) begin
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
    end else begin
      id_ready = 1'b1;
    end
    step();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    check_val("consumed_valid", id_valid, 1'b0);
    check_val("next_req", imem_req, 1'b1);
    if (mode == 3) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      check_val("flush_op", OP, 7'h13);
      check_val("flush_imm", imm, 32'd0);
    end
    check_val("next_addr", imem_addr, m_pc);
  endtask

  initial begin
    logic [6:0]  ops [8];
    logic [31:0] r, w, t;
    int          sel;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h7F};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    #3;
    check_val("rst_req", imem_req, 1'b0);
    check_val("rst_valid", id_valid, 1'b0);
    check_val("rst_op", OP, 7'h13);
    check_val("rst_imm", imm, 32'd0);
    check_val("rst_id_pc", id_pc, 32'd0);
    check_val("rst_rd", rd, 5'd0);
    check_val("rst_illegal", illegal, 1'b0);
    step();
    rst = 1'b0;
    m_pc = 32'd0;
    check_val("idle_req", imem_req, 1'b0);
    step();
    check_val("first_req", imem_req, 1'b1);

    fetch_one(32'h00A0_0093, 0, 0, 32'd0, 0);
    fetch_one(32'hFE20_8EE3, 1, 0, 32'd0, 3);
    fetch_one(32'h1234_5678, 2, 1, 32'h0000_0103, 0);
    fetch_one(32'h0000_0013, 1, 2, 32'h0000_0200, 0);
    fetch_one(32'h0000_A103, 0, 0, 32'd0, 1);
    fetch_one(32'h0011_2223, 1, 0, 32'd0, 0);
    fetch_one(32'h0000_007F, 0, 0, 32'd0, 1);
    fetch_one(32'h0000_0013, 0, 2, 32'hFFFF_FFFC, 0);
    fetch_one(32'h0040_006F, 0, 0, 32'd0, 0);
    fetch_one(32'h8000_0067, 1, 3, 32'h0000_0F0E, 2);

    for (int i = 0; i < 60; i++) begin
      r   = $urandom;
      w   = {r[31:7], ops[$urandom_range(0, 7)]};
      t   = $urandom;
      sel = $urandom_range(0, 5);
      fetch_one(w, $urandom_range(0, 3), (sel < 3) ? 0 : sel - 2, t, $urandom_range(0, 3));
    end

    // async reset while a request is outstanding, with a late ack during reset
    check_val("pre_rst_req", imem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_val("async_req", imem_req, 1'b0);
    check_val("async_addr", imem_addr, 32'd0);
    check_val("async_valid", id_valid, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0093;
    step();
    step();
    imem_ack = 1'b0;
    rst = 1'b0;
    m_pc = 32'd0;
    step();
    check_val("rerst_req", imem_req, 1'b1);
    check_val("rerst_addr", imem_addr, 32'd0);
    check_val("rerst_valid", id_valid, 1'b0);
    fetch_one(32'h0011_2223, 0, 0, 32'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
